uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_core.sv | 135 +++++++++++++
 tb/tb_uart_rx_core.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_pkg -- shared UART receiver types and constants.   Rev 1.0          |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int unsigned OVERSAMPLE         = 8;
  localparam int unsigned DEFAULT_PRESCALE_W = 16;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_core.sv
// +--------------------------------------------------------------------------+
// | uart_rx_core -- 8x-oversampled UART receiver with AXI-Stream output.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rxd,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error
);

  localparam int CNT_W = PRESCALE_W + 3;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  rx_state_e             state_q;
  logic [PRESCALE_W-1:0] p_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] shift_q;

  logic [PRESCALE_W-1:0] p_eff_d;
  logic [CNT_W-1:0]      half_reload_d;
  logic [CNT_W-1:0]      bit_reload_d;
  logic                  cnt_done_d;

  // Half a bit period from the falling edge lands every later sample mid-bit.
  assign p_eff_d       = (prescale == '0) ? PRESCALE_W'(1) : prescale;
  assign half_reload_d = CNT_W'(p_eff_d) * CNT_W'(OVERSAMPLE / 2) - CNT_W'(1);
  assign bit_reload_d  = CNT_W'(p_q) * CNT_W'(OVERSAMPLE) - CNT_W'(1);
  assign cnt_done_d    = (cnt_q == '0);

  assign busy = (state_q != RX_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= RX_IDLE;
      p_q           <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state_q)
        RX_IDLE: begin
          if (!rxd) begin
            p_q     <= p_eff_d;
            cnt_q   <= half_reload_d;
            state_q <= RX_START;
          end
        end

        RX_START: begin
          if (cnt_done_d) begin
            if (!rxd) begin
              cnt_q   <= bit_reload_d;
              idx_q   <= '0;
              state_q <= RX_DATA;
            end else begin
              state_q <= RX_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        RX_DATA: begin
          if (cnt_done_d) begin
            shift_q <= {rxd, shift_q[DATA_WIDTH-1:1]};
            cnt_q   <= bit_reload_d;
            if (idx_q == LAST_IDX) begin
              state_q <= RX_STOP;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        RX_STOP: begin
          if (cnt_done_d) begin
            if (rxd) begin
              // A same-cycle handshake frees the slot, so that is not an overrun.
              m_axis_tdata  <= shift_q;
              m_axis_tvalid <= 1'b1;
              overrun_error <= m_axis_tvalid && !m_axis_tready;
              state_q       <= RX_IDLE;
            end else begin
              frame_error <= 1'b1;
              state_q     <= RX_BREAK;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        RX_BREAK: begin
          if (rxd) begin
            state_q <= RX_IDLE;
          end
        end

        default: begin
          state_q <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// +--------------------------------------------------------------------------+
// | tb_uart_rx_core -- directed self-checking bench for uart_rx_core.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rxd;
  logic [15:0] prescale;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        busy;
  logic        ovr;
  logic        ferr;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int fall_cyc = 0;

  int          rise_cnt  = 0;
  int          rise_edge = 0;
  logic [7:0]  rise_data = 8'h00;
  logic        prev_v    = 1'b0;
  int          ovr_cnt   = 0;
  int          ferr_cnt  = 0;

  uart_rx_core #(
    .DATA_WIDTH(8),
    .PRESCALE_W(16)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .rxd          (rxd),
    .prescale     (prescale),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .busy         (busy),
    .overrun_error(ovr),
    .frame_error  (ferr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge/pulse recorder sampled on the falling clock edge.
  always @(negedge clk) begin
    if (tvalid === 1'b1 && prev_v !== 1'b1) begin
      rise_cnt  <= rise_cnt + 1;
      rise_edge <= cyc;
      rise_data <= tdata;
    end
    prev_v <= tvalid;
    if (ovr === 1'b1)  ovr_cnt  <= ovr_cnt + 1;
    if (ferr === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // Drives one frame starting at a falling edge; prescale is scrambled after detect.
  task automatic send_frame(input int p, input logic [7:0] d, input logic stop, input int hold);
    int t;
    t = 8 * ((p == 0) ? 1 : p);
    @(negedge clk);
    prescale = p[15:0];
    rxd      = 1'b0;
    fall_cyc = cyc;
    repeat (2) @(negedge clk);
    prescale = 16'd7;
    repeat (t - 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (t) @(negedge clk);
    end
    rxd = stop;
    repeat (t + hold) @(negedge clk);
    rxd = 1'b1;
  endtask

  typedef struct {
    int         p;
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_tdata;
    int         exp_rise;
    int         exp_ferr;
    int         exp_lat;
  } vec_t;

  vec_t vt [6];

  initial begin
    int r0, f0, o0;
    int k;

    vt[0] = '{2, 8'hA5, 1'b1, 8'hA5, 1, 0, 152};
    vt[1] = '{1, 8'h3C, 1'b0, 8'hA5, 0, 1, 0};
    vt[2] = '{0, 8'h81, 1'b1, 8'h81, 1, 0, 76};
    vt[3] = '{3, 8'h5A, 1'b1, 8'h5A, 1, 0, 228};
    vt[4] = '{1, 8'hFF, 1'b1, 8'hFF, 1, 0, 76};
    vt[5] = '{1, 8'h00, 1'b1, 8'h00, 1, 0, 76};

    resetn   = 1'b0;
    rxd      = 1'b1;
    tready   = 1'b1;
    prescale = 16'd2;
    #12;
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata",  tdata,  0);
    check("rst_busy",   busy,   0);
    check("rst_ovr",    ovr,    0);
    check("rst_ferr",   ferr,   0);
    @(negedge clk);
    resetn = 1'b1;
    settle(3);

    for (int i = 0; i < 6; i++) begin
      r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(vt[i].p, vt[i].d, vt[i].stop, 0);
      settle(4);
      check($sformatf("v%0d_rise", i),  rise_cnt - r0, vt[i].exp_rise);
      check($sformatf("v%0d_ferr", i),  ferr_cnt - f0, vt[i].exp_ferr);
      check($sformatf("v%0d_ovr", i),   ovr_cnt - o0,  0);
      check($sformatf("v%0d_tdata", i), tdata,         vt[i].exp_tdata);
      check($sformatf("v%0d_busy", i),  busy,          0);
      if (vt[i].exp_rise == 1) begin
        check($sformatf("v%0d_lat", i),   rise_edge - fall_cyc - 1, vt[i].exp_lat);
        check($sformatf("v%0d_rdata", i), rise_data,                vt[i].d);
      end
    end

    // Start glitch: 5 low cycles at prescale 2 return to idle at detect+8.
    r0 = rise_cnt; f0 = ferr_cnt;
    @(negedge clk);
    prescale = 16'd2;
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("glitch_busy_e7", busy, 1);
    @(posedge clk);
    #1 check("glitch_busy_e8", busy, 0);
    settle(20);
    check("glitch_rise", rise_cnt - r0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);

    // Bad stop held low: must sit in BREAK, then idle once the line rises.
    r0 = rise_cnt; f0 = ferr_cnt;
    send_frame(1, 8'h3C, 1'b0, 40);
    #2 check("brk_busy_low", busy, 1);
    @(posedge clk);
    #1 check("brk_busy_high", busy, 0);
    settle(4);
    check("brk_rise", rise_cnt - r0, 0);
    check("brk_ferr", ferr_cnt - f0, 1);
    check("brk_tdata", tdata, 8'h00);

    // Overrun with consumer stalled.
    tready = 1'b0;
    o0 = ovr_cnt;
    send_frame(1, 8'h11, 1'b1, 0);
    settle(4);
    check("ovr_first_valid", tvalid, 1);
    check("ovr_first_data",  tdata,  8'h11);
    send_frame(1, 8'h22, 1'b1, 0);
    settle(4);
    check("ovr_second_valid", tvalid, 1);
    check("ovr_second_data",  tdata,  8'h22);
    check("ovr_pulses",       ovr_cnt - o0, 1);
    @(negedge clk);
    tready = 1'b1;
    @(posedge clk);
    #1 check("ovr_drain_valid", tvalid, 0);
    @(negedge clk);
    tready = 1'b0;

    // Handshake in the exact completion cycle of the next byte.
    send_frame(1, 8'h44, 1'b1, 0);
    settle(4);
    check("hs_pending", tdata, 8'h44);
    o0 = ovr_cnt;
    fork
      send_frame(1, 8'h55, 1'b1, 0);
      begin
        repeat (3) @(negedge clk);
        k = 0;
        while (k < 300 && cyc != fall_cyc + 76) begin
          @(negedge clk);
          k++;
        end
        check("hs_sync", (cyc == fall_cyc + 76) ? 1 : 0, 1);
        tready = 1'b1;
        @(negedge clk);
        tready = 1'b0;
      end
    join
    settle(4);
    check("hs_valid", tvalid, 1);
    check("hs_tdata", tdata,  8'h55);
    check("hs_ovr",   ovr_cnt - o0, 0);
    @(negedge clk);
    tready = 1'b1;
    settle(2);
    check("hs_drain", tvalid, 0);

    // Reset in the middle of the data bits.
    r0 = rise_cnt;
    @(negedge clk);
    prescale = 16'd1;
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    rxd = 1'b1;
    repeat (16) @(negedge clk);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    #3 resetn = 1'b0;
    #1;
    check("mid_rst_busy",  busy,  0);
    check("mid_rst_tdata", tdata, 0);
    @(negedge clk);
    resetn = 1'b1;
    rxd = 1'b1;
    settle(40);
    check("mid_rst_rise", rise_cnt - r0, 0);
    send_frame(1, 8'hF0, 1'b1, 0);
    settle(4);
    check("post_rst_rise",  rise_cnt - r0, 1);
    check("post_rst_rdata", rise_data, 8'hF0);
    check("post_rst_lat",   rise_edge - fall_cyc - 1, 76);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
